// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC      = 4'd3,
    R_WB      = 4'd4,
    MEM_ADDR  = 4'd5,
    MEM_READ  = 4'd6,
    MEM_WB    = 4'd7,
    MEM_WRITE = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    IMM_EXEC  = 4'd11,
    IMM_WB    = 4'd12
  } state_e;

  // Which ALU operation family the current state asks for.
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_ADD   = 3'd1,
    CLS_SUB   = 3'd2,
    CLS_RTYPE = 3'd3,
    CLS_IMM   = 3'd4
  } alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_BRIMM = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_mc_control_alu_ctrl_decode.sv
// Combinational ALU control: maps the requested operation family plus the
// instruction fields onto a 4-bit ALU op, and flags unsupported R-type functs.
module alu_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       funct_illegal_o
);

  logic [3:0] r_op_s;

  // Decode the R-type funct field independently of the current state.
  always_comb begin
    r_op_s          = ALU_AND;
    funct_illegal_o = 1'b0;
    case (funct_i)
      FN_ADD, FN_ADDU: r_op_s = ALU_ADD;
      FN_SUB, FN_SUBU: r_op_s = ALU_SUB;
      FN_AND:          r_op_s = ALU_AND;
      FN_OR:           r_op_s = ALU_OR;
      FN_NOR:          r_op_s = ALU_NOR;
      default: begin
        r_op_s          = ALU_AND;
        funct_illegal_o = 1'b1;
      end
    endcase
  end

  // Select the ALU op for the family the FSM is requesting.
  always_comb begin
    alu_ctrl_o = ALU_AND;
    case (cls_i)
      CLS_ADD:   alu_ctrl_o = ALU_ADD;
      CLS_SUB:   alu_ctrl_o = ALU_SUB;
      CLS_RTYPE: alu_ctrl_o = r_op_s;
      CLS_IMM: begin
        case (opcode_i)
          OP_ANDI: alu_ctrl_o = ALU_AND;
          OP_ORI:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default:   alu_ctrl_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM. Outputs are a decode of the current
// state; only ir_write, pc_en and the pulses look at mem_ready / Zero.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [3:0] ALUctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic       instr_done
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  alu_cls_e   cls_s;
  logic       funct_illegal_s;
  logic       in_mem_s;
  logic       timeout_s;

  alu_ctrl_decode u_alu_ctrl_decode (
    .cls_i           (cls_s),
    .opcode_i        (opcode),
    .funct_i         (funct),
    .alu_ctrl_o      (ALUctrl),
    .funct_illegal_o (funct_illegal_s)
  );

  assign in_mem_s  = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
  assign timeout_s = in_mem_s && !mem_ready && (cnt_q == TIMEOUT_LIM);

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d     = state_q;
    cls_s       = CLS_NONE;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    imm_zext    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_source   = PCSRC_ALU;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    instr_done  = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        cls_s     = CLS_ADD;
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = DECODE;
        end else if (timeout_s) begin
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        cls_s     = CLS_ADD;
        alu_src_b = SRCB_BRIMM;
        case (opcode)
          OP_RTYPE: begin
            if (funct_illegal_s) begin
              illegal_op = 1'b1;
              state_d    = FETCH;
            end else begin
              state_d = EXEC;
            end
          end
          OP_LW, OP_SW:              state_d = MEM_ADDR;
          OP_BEQ:                    state_d = BRANCH;
          OP_J:                      state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = IMM_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      EXEC: begin
        cls_s     = CLS_RTYPE;
        alu_src_a = 1'b1;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_ADDR: begin
        cls_s     = CLS_ADD;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_LW) begin
          state_d = MEM_READ;
        end else begin
          state_d = MEM_WRITE;
        end
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = MEM_WB;
        end else if (timeout_s) begin
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end else begin
          state_d = MEM_READ;
        end
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (timeout_s) begin
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end else begin
          state_d = MEM_WRITE;
        end
      end
      BRANCH: begin
        cls_s      = CLS_SUB;
        alu_src_a  = 1'b1;
        pc_source  = PCSRC_ALUOUT;
        pc_en      = Zero;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      IMM_EXEC: begin
        cls_s     = CLS_IMM;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI);
        state_d   = IMM_WB;
      end
      IMM_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait counter: restarts on any state entry (including a timed-out
  // re-entry of FETCH) and counts cycles spent waiting for mem_ready.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || timeout_s) begin
      cnt_d = 8'd0;
    end else if (in_mem_s && !mem_ready) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed, table-driven bench for the multi-cycle MIPS control FSM.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] ALUctrl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext, iord, mem_read, mem_write, ir_write, pc_en;
  logic [1:0] pc_source;
  logic       reg_dst, mem_to_reg, reg_write, illegal_op, mem_timeout, instr_done;

  int checks = 0;
  int errors = 0;

  mips_mc_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .ALUctrl(ALUctrl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  logic [21:0] act_s;
  assign act_s = {ALUctrl, alu_src_a, alu_src_b, imm_zext, iord, mem_read, mem_write,
                  ir_write, pc_en, pc_source, reg_dst, mem_to_reg, reg_write,
                  illegal_op, mem_timeout, instr_done};

  function automatic logic [21:0] o(
    input logic [3:0] alu, input logic sa, input logic [1:0] sb, input logic zx,
    input logic io, input logic mr, input logic mw, input logic irw, input logic pce,
    input logic [1:0] ps, input logic rd, input logic m2r, input logic rw,
    input logic ill, input logic to, input logic done);
    return {alu, sa, sb, zx, io, mr, mw, irw, pce, ps, rd, m2r, rw, ill, to, done};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [21:0] exp);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [21:0] E_IDLE, E_FETCH, E_FWAIT, E_FTO, E_DEC, E_DECILL, E_EXNOR, E_EXSUB;
  logic [21:0] E_RWB, E_MADDR, E_MRD, E_MWB, E_MWR, E_BR1, E_BR0, E_JMP;
  logic [21:0] E_IORI, E_IADDI, E_IWB;

  initial begin
    E_IDLE   = o(4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    E_FETCH  = o(4'd2,  1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    E_FWAIT  = o(4'd2,  1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    E_FTO    = o(4'd2,  1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    E_DEC    = o(4'd2,  1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    E_DECILL = o(4'd2,  1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    E_EXNOR  = o(4'd12, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    E_EXSUB  = o(4'd6,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    E_RWB    = o(4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    E_MADDR  = o(4'd2,  1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    E_MRD    = o(4'd0,  1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    E_MWB    = o(4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    E_MWR    = o(4'd0,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    E_BR1    = o(4'd6,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    E_BR0    = o(4'd6,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    E_JMP    = o(4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    E_IORI   = o(4'd1,  1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    E_IADDI  = o(4'd2,  1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    E_IWB    = o(4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // R-type NOR, mem_ready low in non-memory states must not matter
    add(6'h00, 6'h27, 1'b0, 1'b1, E_IDLE);
    add(6'h00, 6'h27, 1'b0, 1'b1, E_FETCH);
    add(6'h00, 6'h27, 1'b0, 1'b0, E_DEC);
    add(6'h00, 6'h27, 1'b0, 1'b0, E_EXNOR);
    add(6'h00, 6'h27, 1'b0, 1'b1, E_RWB);
    // lw with three wait cycles in MEM_READ
    add(6'h23, 6'h00, 1'b0, 1'b1, E_FETCH);
    add(6'h23, 6'h00, 1'b0, 1'b1, E_DEC);
    add(6'h23, 6'h00, 1'b0, 1'b1, E_MADDR);
    add(6'h23, 6'h00, 1'b0, 1'b0, E_MRD);
    add(6'h23, 6'h00, 1'b0, 1'b0, E_MRD);
    add(6'h23, 6'h00, 1'b0, 1'b0, E_MRD);
    add(6'h23, 6'h00, 1'b0, 1'b1, E_MRD);
    add(6'h23, 6'h00, 1'b0, 1'b1, E_MWB);
    // beq taken then not taken
    add(6'h04, 6'h00, 1'b1, 1'b1, E_FETCH);
    add(6'h04, 6'h00, 1'b1, 1'b1, E_DEC);
    add(6'h04, 6'h00, 1'b1, 1'b0, E_BR1);
    add(6'h04, 6'h00, 1'b0, 1'b1, E_FETCH);
    add(6'h04, 6'h00, 1'b0, 1'b1, E_DEC);
    add(6'h04, 6'h00, 1'b0, 1'b1, E_BR0);
    // ori
    add(6'h0D, 6'h00, 1'b0, 1'b1, E_FETCH);
    add(6'h0D, 6'h00, 1'b0, 1'b1, E_DEC);
    add(6'h0D, 6'h00, 1'b0, 1'b1, E_IORI);
    add(6'h0D, 6'h00, 1'b0, 1'b1, E_IWB);
    // illegal opcode, then illegal R-type funct
    add(6'h3F, 6'h00, 1'b0, 1'b1, E_FETCH);
    add(6'h3F, 6'h00, 1'b0, 1'b1, E_DECILL);
    add(6'h00, 6'h2A, 1'b0, 1'b1, E_FETCH);
    add(6'h00, 6'h2A, 1'b0, 1'b1, E_DECILL);
    // FETCH timeout after 4 waits, then ready exactly at the limit succeeds
    for (int i = 0; i < 4; i++) add(6'h2B, 6'h00, 1'b0, 1'b0, E_FWAIT);
    add(6'h2B, 6'h00, 1'b0, 1'b0, E_FTO);
    for (int i = 0; i < 4; i++) add(6'h2B, 6'h00, 1'b0, 1'b0, E_FWAIT);
    add(6'h2B, 6'h00, 1'b0, 1'b1, E_FETCH);
    add(6'h2B, 6'h00, 1'b0, 1'b1, E_DEC);
    add(6'h2B, 6'h00, 1'b0, 1'b1, E_MADDR);
    add(6'h2B, 6'h00, 1'b0, 1'b1, E_MWR);
    // j
    add(6'h02, 6'h00, 1'b0, 1'b1, E_FETCH);
    add(6'h02, 6'h00, 1'b0, 1'b1, E_DEC);
    add(6'h02, 6'h00, 1'b0, 1'b1, E_JMP);
    // addi
    add(6'h08, 6'h00, 1'b0, 1'b1, E_FETCH);
    add(6'h08, 6'h00, 1'b0, 1'b1, E_DEC);
    add(6'h08, 6'h00, 1'b0, 1'b1, E_IADDI);
    add(6'h08, 6'h00, 1'b0, 1'b1, E_IWB);
    // R-type SUBU
    add(6'h00, 6'h23, 1'b0, 1'b1, E_FETCH);
    add(6'h00, 6'h23, 1'b0, 1'b1, E_DEC);
    add(6'h00, 6'h23, 1'b0, 1'b1, E_EXSUB);
    add(6'h00, 6'h23, 1'b0, 1'b1, E_RWB);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", act_s, E_IDLE);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode    = vecs[i].op;
      funct     = vecs[i].fn;
      Zero      = vecs[i].z;
      mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d", i), act_s, vecs[i].exp);
      @(negedge clk);
    end

    // Reset asserted in the middle of a sw abandons it immediately
    opcode = 6'h2B; funct = 6'h00; Zero = 1'b0; mem_ready = 1'b1;
    #1; chk("sw_fetch", act_s, E_FETCH);
    @(negedge clk); #1; chk("sw_decode", act_s, E_DEC);
    @(negedge clk); #1; chk("sw_maddr", act_s, E_MADDR);
    @(negedge clk);
    mem_ready = 1'b0;
    #1; chk("sw_wait", act_s, o(4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                               2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    #1; rst_n = 1'b0;
    #1; chk("midreset_outputs", act_s, E_IDLE);
    @(negedge clk); #1; chk("midreset_hold", act_s, E_IDLE);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1; chk("post_reset_idle", act_s, E_IDLE);
    @(negedge clk); #1; chk("post_reset_fetch", act_s, E_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
